// File: rtl/memory_access_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package memory_access_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RESPOND = 2'd2
  } arb_state_t;

  // Requester identities; also the encoding held in last_grant
  typedef enum logic {
    ARB_INST = 1'b0,
    ARB_DATA = 1'b1
  } arb_id_t;

  // funct3 code for a full 32-bit word access; fetches always use it
  localparam logic [2:0] WIDTH_WORD = 3'b010;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 15;

  // True when a latency value fits the 4-bit countdown and is non-zero
  function automatic bit latency_ok(input int lat);
    return (lat >= MEM_LATENCY_MIN) && (lat <= MEM_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/memory_access_arbiter_if.sv
// Requester and memory-port bundle of the arbiter.
// slave: the arbiter side. master: requesters plus the memory model.
interface memory_access_arbiter_if;

  // instruction-fetch requester
  logic        inst_req;
  logic [31:0] inst_address;
  logic        inst_grant;
  logic [31:0] inst_data;

  // load/store requester
  logic        data_req;
  logic        data_write_enable;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [2:0]  data_width;
  logic        data_grant;
  logic [31:0] data_read_data;

  // shared memory port
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_width;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_data_fetched;

  modport slave (
    input  inst_req, inst_address,
    output inst_grant, inst_data,
    input  data_req, data_write_enable, data_address, data_write_data, data_width,
    output data_grant, data_read_data,
    output mem_address, mem_write_data, mem_width, mem_read_enable, mem_write_enable,
    input  mem_data_fetched
  );

  modport master (
    output inst_req, inst_address,
    input  inst_grant, inst_data,
    output data_req, data_write_enable, data_address, data_write_data, data_width,
    input  data_grant, data_read_data,
    input  mem_address, mem_write_data, mem_width, mem_read_enable, mem_write_enable,
    output mem_data_fetched
  );

endinterface

// File: rtl/memory_access_arbiter_rr_select2.sv
// Combinational two-requester round-robin picker.
// On a tie the requester that did not win the last tie is chosen.
module rr_select2
  import memory_access_arbiter_pkg::*;
(
  input  logic    req_inst,
  input  logic    req_data,
  input  arb_id_t last_grant,
  output arb_id_t winner,
  output logic    any
);

  // Pick a winner: a lone requester wins outright, a tie goes to the other side
  always_comb begin
    any    = req_inst | req_data;
    winner = ARB_INST;
    if (req_inst && req_data) begin
      winner = (last_grant == ARB_INST) ? ARB_DATA : ARB_INST;
    end else if (req_data) begin
      winner = ARB_DATA;
    end
  end

endmodule

// File: rtl/memory_access_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction at a time: accept in IDLE, hold the port for
// MEM_LATENCY cycles in BUSY, pulse the winner's grant in RESPOND.
module memory_access_arbiter
  import memory_access_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  memory_access_arbiter_if.slave bus
);

  // Reject latencies the 4-bit countdown cannot represent
  if (!latency_ok(MEM_LATENCY)) begin : g_latency_check
    $error("memory_access_arbiter: MEM_LATENCY must be within 1..15");
  end

  localparam logic [3:0] COUNT_LOAD = 4'(MEM_LATENCY - 1);

  arb_state_t  state_reg, state_next;
  arb_id_t     last_grant_reg, last_grant_next;
  arb_id_t     owner_reg, owner_next;
  arb_id_t     winner;
  logic        any_req;
  logic [3:0]  count_reg, count_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  width_reg, width_next;
  logic        we_reg, we_next;
  logic [31:0] inst_data_reg, inst_data_next;
  logic [31:0] data_rd_reg, data_rd_next;
  logic        inst_grant_reg, inst_grant_next;
  logic        data_grant_reg, data_grant_next;
  logic        mem_re_reg, mem_re_next;
  logic        mem_we_reg, mem_we_next;

  rr_select2 u_rr_select2 (
    .req_inst   (bus.inst_req),
    .req_data   (bus.data_req),
    .last_grant (last_grant_reg),
    .winner     (winner),
    .any        (any_req)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, leave BUSY when the countdown is spent
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:    if (any_req) state_next = ARB_BUSY;
      ARB_BUSY:    if (count_reg == 4'd0) state_next = ARB_RESPOND;
      ARB_RESPOND: state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  // Transaction capture, countdown and read-data capture
  always_comb begin
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    count_next      = count_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    width_next      = width_reg;
    we_next         = we_reg;
    inst_data_next  = inst_data_reg;
    data_rd_next    = data_rd_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (any_req) begin
          owner_next = winner;
          count_next = COUNT_LOAD;
          // Only a genuine tie moves the round-robin pointer
          if (bus.inst_req && bus.data_req) begin
            last_grant_next = winner;
          end
          if (winner == ARB_DATA) begin
            addr_next  = bus.data_address;
            wdata_next = bus.data_write_data;
            width_next = bus.data_width;
            we_next    = bus.data_write_enable;
          end else begin
            addr_next  = bus.inst_address;
            wdata_next = 32'd0;
            width_next = WIDTH_WORD;
            we_next    = 1'b0;
          end
        end
      end
      ARB_BUSY: begin
        if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end else if (owner_reg == ARB_DATA) begin
          // stores capture too; the value is simply unused
          data_rd_next = bus.mem_data_fetched;
        end else begin
          inst_data_next = bus.mem_data_fetched;
        end
      end
      default: ;
    endcase
  end

  // Output logic: derive next-cycle strobes and grants from the next state
  always_comb begin
    mem_re_next     = 1'b0;
    mem_we_next     = 1'b0;
    inst_grant_next = 1'b0;
    data_grant_next = 1'b0;
    case (state_next)
      ARB_BUSY: begin
        mem_re_next = !we_next;
        mem_we_next = we_next;
      end
      ARB_RESPOND: begin
        inst_grant_next = (owner_next == ARB_INST);
        data_grant_next = (owner_next == ARB_DATA);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= ARB_DATA;
      owner_reg      <= ARB_INST;
      count_reg      <= 4'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      width_reg      <= 3'd0;
      we_reg         <= 1'b0;
      inst_data_reg  <= 32'd0;
      data_rd_reg    <= 32'd0;
    end else begin
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      count_reg      <= count_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      width_reg      <= width_next;
      we_reg         <= we_next;
      inst_data_reg  <= inst_data_next;
      data_rd_reg    <= data_rd_next;
    end
  end

  // Registered strobes and grants; reset clears them without waiting for a clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_grant_reg <= 1'b0;
      data_grant_reg <= 1'b0;
      mem_re_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
    end else begin
      inst_grant_reg <= inst_grant_next;
      data_grant_reg <= data_grant_next;
      mem_re_reg     <= mem_re_next;
      mem_we_reg     <= mem_we_next;
    end
  end

  assign bus.mem_address      = addr_reg;
  assign bus.mem_write_data   = wdata_reg;
  assign bus.mem_width        = width_reg;
  assign bus.mem_read_enable  = mem_re_reg;
  assign bus.mem_write_enable = mem_we_reg;
  assign bus.inst_grant       = inst_grant_reg;
  assign bus.inst_data        = inst_data_reg;
  assign bus.data_grant       = data_grant_reg;
  assign bus.data_read_data   = data_rd_reg;

endmodule
